uart_apb_master: RTL and testbench
==================================

# uart_apb_master

APB initiator that issues single register transfers to the UART's APB slave port (PSEL/PENABLE/PWRITE/PADDR/PWDATA in; PRDATA/PREADY/PSLVERR out). It accepts one command at a time on a valid/ready request channel, runs the APB SETUP and ACCESS phases including wait states, and returns read data and error status on a valid/ready response channel. It is used by the UART bring-up bench and by on-chip sequencers that configure the UART without a CPU.

## Interface
- ADDR_W, 8, PADDR width
- DATA_W, 8, PWDATA/PRDATA width
- TIMEOUT, 16, wait-state limit in PCLK cycles; used only with UART_APB_MASTER_TIMEOUT_EN; legal range 2..255
- PCLK  in  1  single clock; all logic on its rising edge
- PRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target register address
- cmd_wdata  in  DATA_W  write data; ignored on reads
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes and errored reads
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W; PWDATA  out  DATA_W
- PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state: IDLE.
- IDLE: cmd_ready=1, all other outputs hold. On cmd_valid, latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. While PREADY=0, stay (wait state). When PREADY=1:
  - capture rsp_err = PSLVERR;
  - capture rsp_rdata = PRDATA for an error-free read, else 0;
  - drop PSEL/PENABLE the next cycle and go to RESP.
- RESP: rsp_valid=1, response fields stable. On rsp_ready, go to IDLE. rsp_valid drops the cycle after the handshake.
- cmd_ready is 0 in SETUP, ACCESS and RESP. Commands offered then are not consumed and must be held by the source.
- PADDR/PWRITE/PWDATA are constant from SETUP through the last ACCESS cycle and hold their last values afterwards. They update only on command acceptance.
- PRDATA, PREADY and PSLVERR are ignored outside ACCESS.
- Reset (asynchronous, any state): the FSM returns to IDLE and every output goes to 0 except cmd_ready=1. Any in-flight transfer is abandoned and produces no response.

## Timing
- Cycle 0: command handshake. Cycle 1: SETUP. Cycle 2: first ACCESS. With PREADY=1 in cycle 2, rsp_valid=1 in cycle 3.
- Each PREADY-low cycle adds one cycle of latency.
- Minimum command-to-command spacing is 4 cycles: the next cmd_ready=1 comes the cycle after the rsp handshake, and RESP lasts at least one cycle.
- Outputs are all registered except cmd_ready, which is decoded from the state register.

## Configuration
- UART_APB_MASTER_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When PREADY is still 0 in the TIMEOUT-th consecutive ACCESS cycle, the transfer aborts: PSEL/PENABLE drop the next cycle, RESP is entered with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - If PREADY=1 in that same cycle, the transfer completes normally.
- UART_APB_MASTER_TIMEOUT_EN undefined:
  - No counter; ACCESS waits indefinitely for PREADY.
  - rsp_timeout is tied to 0.

## Test plan
- Zero-wait write: cmd write addr 0x03 data 0x1B, PREADY=1 → PSEL high cycles 1–2, PENABLE high in cycle 2 only, PADDR=0x03, PWDATA=0x1B, rsp_valid in cycle 3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: cmd read addr 0x05, PREADY low for 3 ACCESS cycles, then high with PRDATA=0x60 → rsp_valid in cycle 6, rsp_rdata=0x60, PADDR stable throughout.
- Slave error: read addr 0xFF, PSLVERR=1 with PREADY → rsp_err=1, rsp_rdata=0, rsp_timeout=0.
- Back-pressure: rsp_ready held low for 5 cycles → rsp_valid and its fields stay stable, cmd_ready=0 with cmd_valid held; after the handshake, cmd_ready=1 in the next cycle and the queued command is accepted.
- Timeout (macro on, TIMEOUT=4): PREADY held 0 → PSEL drops after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1. With the macro off, the bench holds PREADY low for 100 cycles and sees PSEL=PENABLE=1 throughout.
- Reset mid-ACCESS: assert PRESET while PENABLE=1 → PSEL=PENABLE=0 and rsp_valid=0 immediately, cmd_ready=1, and no response after release.

Source files
------------

// File: rtl/uart_apb_master_if.sv
// uart_apb_master_if
//   Bundles the command/response channels and the APB bus of the UART
//   register initiator.
//   Parameters: ADDR_W (PADDR/cmd_addr width), DATA_W (data width).
//   Modports:
//     master - the initiator itself: takes commands, returns responses and
//              drives PSEL/PENABLE/PWRITE/PADDR/PWDATA.
//     slave  - the environment: issues commands, consumes responses and
//              plays the APB completer (PRDATA/PREADY/PSLVERR).
interface uart_apb_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  // APB bus
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/uart_apb_master.sv
// uart_apb_master
//   APB initiator issuing single register transfers to the UART slave port.
//   One command at a time is taken on the valid/ready command channel, the
//   APB SETUP and ACCESS phases are run (wait states included) and the
//   read data / error status is returned on the valid/ready response channel.
//   Ports:
//     PCLK   - single clock, rising edge
//     PRESET - asynchronous active-high reset
//     bus    - uart_apb_master_if.master (command, response and APB signals)
//   Parameters: ADDR_W, DATA_W, TIMEOUT (wait-state limit, 2..255).
//   Optional feature: define UART_APB_MASTER_TIMEOUT_EN to abort a transfer
//   whose completer keeps PREADY low for TIMEOUT consecutive ACCESS cycles.
//   Every output is registered except cmd_ready, decoded from the state.
module uart_apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input logic                PCLK,
  input logic                PRESET,
  uart_apb_master_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Reject unusable wait-state limits at elaboration.
  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("uart_apb_master: TIMEOUT must be within 2..255");
  end

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              timeout_hit_s;
  logic              access_end_s;

`ifdef UART_APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  // Wait-state counter: cleared in SETUP so it reads 0 in the first ACCESS cycle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_SETUP) begin
      wait_cnt_d = 8'd0;
    end else if ((state_q == ST_ACCESS) && !bus.PREADY) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Wait-state counter register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Counter holds k-1 in the k-th ACCESS cycle, so this fires on the
  // TIMEOUT-th one; a PREADY in that cycle still wins.
  assign timeout_hit_s = (state_q == ST_ACCESS) && !bus.PREADY && (wait_cnt_q == WAIT_LAST);
`else
  assign timeout_hit_s = 1'b0;
`endif

  assign access_end_s = bus.PREADY | timeout_hit_s;

  // State and output registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= {ADDR_W{1'b0}};
      pwdata_q      <= {DATA_W{1'b0}};
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {DATA_W{1'b0}};
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = bus.cmd_valid ? ST_SETUP : ST_IDLE;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: state_d = access_end_s ? ST_RESP : ST_ACCESS;
      ST_RESP:   state_d = bus.rsp_ready ? ST_IDLE : ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless changed.
  always_comb begin
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          psel_d   = 1'b1;
          penable_d = 1'b0;
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
        end else begin
          psel_d = psel_q;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (access_end_s) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          // A timeout only happens with PREADY low, so PREADY selects the source.
          rsp_err_d     = bus.PREADY ? bus.PSLVERR : 1'b1;
          rsp_timeout_d = ~bus.PREADY;
          rsp_rdata_d   = (bus.PREADY && !pwrite_q && !bus.PSLVERR) ? bus.PRDATA : {DATA_W{1'b0}};
        end else begin
          rsp_valid_d = rsp_valid_q;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
        end else begin
          rsp_valid_d = rsp_valid_q;
        end
      end
      default: begin
        psel_d = psel_q;
      end
    endcase
  end

  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// tb_uart_apb_master
//   Randomized bench for uart_apb_master. A driver issues commands and plays
//   the APB completer; at command acceptance the expected response, computed
//   by a reference function from the transfer's wait count / error / data, is
//   pushed into a scoreboard queue. A separate monitor compares every cycle
//   in which rsp_valid is high against the queue head and pops on handshake.
//   Protocol timing (PSEL/PENABLE phases, latency, address stability, reset)
//   is checked inline by the driver.
module tb_uart_apb_master;
  localparam int AW         = 8;
  localparam int DW         = 8;
  localparam int TB_TIMEOUT = 4;
`ifdef UART_APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       tmo;
  } rsp_t;

  logic PCLK = 1'b0;
  logic PRESET;
  rsp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  uart_apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  uart_apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TB_TIMEOUT)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: response of one transfer from the completer's behaviour.
  function automatic rsp_t ref_rsp(input bit wr, input int waits, input bit slverr,
                                   input logic [7:0] prdata);
    rsp_t r;
    if (TO_EN && (waits >= TB_TIMEOUT)) begin
      r.rdata = 8'h00; r.err = 1'b1; r.tmo = 1'b1;
    end else begin
      r.err   = slverr;
      r.tmo   = 1'b0;
      r.rdata = (wr || slverr) ? 8'h00 : prdata;
    end
    return r;
  endfunction

  // Random junk on completer signals; must be ignored outside ACCESS.
  task automatic junk_apb();
    bus.PREADY  = 1'($urandom_range(0, 1));
    bus.PSLVERR = 1'($urandom_range(0, 1));
    bus.PRDATA  = 8'($urandom);
  endtask

  // One transfer; called and returns at a falling edge.
  task automatic do_xfer(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                         input int waits, input bit slverr, input logic [7:0] prdata,
                         input int hold, input bit bp_cmd, input bit nwr,
                         input logic [7:0] naddr, input logic [7:0] ndata);
    int  guard;
    int  k;
    bit  aborted;
    bit  last;
    bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = data; bus.cmd_valid = 1'b1;
    junk_apb();
    guard = 0;
    while ((bus.cmd_ready !== 1'b1) && (guard < 20)) begin
      @(negedge PCLK); junk_apb(); guard++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      check("cmd_accept_bound", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    sb_q.push_back(ref_rsp(wr, waits, slverr, prdata));
    @(negedge PCLK);
    // SETUP: scramble the command inputs, PADDR etc. must not follow them
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr = 8'($urandom); bus.cmd_wdata = 8'($urandom);
    junk_apb();
    check("setup_ctrl", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready}), 32'b1000);
    check("setup_bus", 32'({bus.PWRITE, bus.PADDR, bus.PWDATA}), 32'({wr, addr, data}));
    aborted = TO_EN && (waits >= TB_TIMEOUT);
    k = 0;
    forever begin
      @(negedge PCLK);
      check("access_ctrl", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready}), 32'b1100);
      check("access_bus", 32'({bus.PWRITE, bus.PADDR, bus.PWDATA}), 32'({wr, addr, data}));
      last = aborted ? (k == TB_TIMEOUT - 1) : (k == waits);
      if (!aborted && (k == waits)) begin
        bus.PREADY = 1'b1; bus.PSLVERR = slverr; bus.PRDATA = prdata;
      end else begin
        bus.PREADY = 1'b0; bus.PSLVERR = 1'($urandom_range(0, 1)); bus.PRDATA = 8'($urandom);
      end
      if (last) break;
      k++;
    end
    @(negedge PCLK);
    junk_apb();
    check("resp_ctrl", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready}), 32'b0010);
    check("resp_bus_hold", 32'({bus.PWRITE, bus.PADDR, bus.PWDATA}), 32'({wr, addr, data}));
    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready = 1'b0;
      if (bp_cmd) begin
        bus.cmd_valid = 1'b1; bus.cmd_write = nwr; bus.cmd_addr = naddr; bus.cmd_wdata = ndata;
      end
      @(negedge PCLK);
      junk_apb();
      check("bp_hold", 32'({bus.rsp_valid, bus.cmd_ready, bus.PSEL}), 32'b100);
    end
    bus.rsp_ready = 1'b1;
    @(negedge PCLK);
    bus.rsp_ready = 1'b0;
    junk_apb();
    check("post_rsp", 32'({bus.rsp_valid, bus.cmd_ready, bus.PSEL}), 32'b010);
  endtask

  // Reset asserted in the middle of a wait-stated ACCESS phase.
  task automatic reset_mid_access();
    int guard;
    int bad;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'($urandom);
    guard = 0;
    while ((bus.cmd_ready !== 1'b1) && (guard < 20)) begin
      @(negedge PCLK); guard++;
    end
    @(negedge PCLK);
    bus.cmd_valid = 1'b0; bus.PREADY = 1'b0;
    @(negedge PCLK);
    bus.PREADY = 1'b0;
    @(negedge PCLK);
    bus.PREADY = 1'b0;
    check("pre_reset_ctrl", 32'({bus.PSEL, bus.PENABLE}), 32'b11);
    #2 PRESET = 1'b1;
    #1;
    check("reset_async", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready}), 32'b0001);
    @(negedge PCLK);
    PRESET = 1'b0; bus.rsp_ready = 1'b1; bus.PREADY = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) bad++;
    end
    bus.rsp_ready = 1'b0;
    check("no_rsp_after_reset", 32'(bad), 32'd0);
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    forever begin
      @(negedge PCLK);
      #1;
      if (!PRESET && bus.rsp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          check("rsp_fields", 32'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}),
                32'({sb_q[0].rdata, sb_q[0].err, sb_q[0].tmo}));
          if (bus.rsp_ready === 1'b1) void'(sb_q.pop_front());
        end
      end
    end
  end

  // Watchdog against a stuck run.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    PRESET = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h00; bus.cmd_wdata = 8'h00;
    bus.rsp_ready = 1'b0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = 8'h00;
    repeat (3) @(negedge PCLK);
    check("reset_ctrl", 32'({bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE,
                             bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}), 32'b1000000);
    check("reset_data", 32'({bus.PADDR, bus.PWDATA, bus.rsp_rdata}), 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Zero-wait write, 3-wait read, slave error
    do_xfer(1'b1, 8'h03, 8'h1B, 0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    do_xfer(1'b0, 8'h05, 8'h00, 3, 1'b0, 8'h60, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    do_xfer(1'b0, 8'hFF, 8'h00, 0, 1'b1, 8'hA5, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Back-pressure with a queued command, then that command
    do_xfer(1'b0, 8'h10, 8'h00, 1, 1'b0, 8'h3C, 5, 1'b1, 1'b1, 8'h22, 8'h44);
    do_xfer(1'b1, 8'h22, 8'h44, 0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);
`ifdef UART_APB_MASTER_TIMEOUT_EN
    do_xfer(1'b0, 8'h07, 8'h00, TB_TIMEOUT,     1'b0, 8'h99, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    do_xfer(1'b0, 8'h07, 8'h00, TB_TIMEOUT - 1, 1'b0, 8'h99, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    do_xfer(1'b1, 8'h08, 8'h5A, 20,             1'b0, 8'h00, 2, 1'b0, 1'b0, 8'h00, 8'h00);
`else
    do_xfer(1'b0, 8'h07, 8'h00, 100, 1'b0, 8'h99, 0, 1'b0, 1'b0, 8'h00, 8'h00);
`endif

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      do_xfer(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 6)),
              ($urandom_range(0, 3) == 0), 8'($urandom), int'($urandom_range(0, 3)),
              1'b0, 1'b0, 8'h00, 8'h00);
    end

    reset_mid_access();
    do_xfer(1'b0, 8'h42, 8'h00, 2, 1'b0, 8'hC3, 0, 1'b0, 1'b0, 8'h00, 8'h00);

    guard = 0;
    while ((sb_q.size() != 0) && (guard < 20)) begin
      @(negedge PCLK); guard++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
